tick_period_meter: RTL and testbench
====================================

# tick_period_meter

Measures the interval, in `clk` cycles, between consecutive rising edges of a tick input and reports it as a count. It is the receiving end of the timer's `tick` output: the timer turns a loaded count into a periodic tick, and this block turns a periodic tick back into a count. It sits beside the timer in the timer example, for self-checking reload values and for measuring external pulse trains.

## Interface
- `WIDTH`, default 8: width of the period counter and of `q`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  measurement enable, level-sensitive.
- `tick_in`  in  1  tick/pulse stream to measure; synchronous to `clk` unless `PERIOD_METER_SYNC_EN` is defined.
- `q`  out  WIDTH  last captured period in cycles, saturating.
- `valid`  out  1  one-cycle pulse when `q` has just been updated.
- `ovf`  out  1  the captured period saturated; updated together with `q`.
- `busy`  out  1  high while in MEASURE.

## Operation
- Edge detect: `tick_q` is the registered `tick_in`. `edge = tick_in & ~tick_q`, or the synchronized equivalent.
- State machine states are IDLE, ARMED and MEASURE.
- IDLE:
  - Counter `cnt` is held at 0.
  - `en = 1` → ARMED on the next clock.
- ARMED:
  - `en = 0` → IDLE.
  - `edge` → MEASURE, `cnt <= 1`, overflow-pending flag cleared.
  - The first edge only starts timing; it never produces `valid`.
- MEASURE:
  - `en = 0` → IDLE, `cnt <= 0`; no capture; `q` and `ovf` hold.
  - `edge` → `q <= cnt`, `ovf <= pend`, `valid <= 1`, `cnt <= 1`, `pend <= 0`; stay in MEASURE, so back-to-back periods are measured with no dead cycle.
  - Otherwise, if `cnt == 2^WIDTH-1`, then `cnt` holds and `pend <= 1`; else `cnt <= cnt + 1`.
- Priority: `en = 0` beats a simultaneous `edge`, so no capture occurs.
- Period definition: for edges sampled at cycles n and n+P, the captured `q` is P.
  - Minimum legal P is 2, because `tick_in` must be low for at least one sample between edges.
  - For P > 2^WIDTH-1, `q = 2^WIDTH-1` and `ovf = 1`.
- `tick_in` held high: no further edges are detected, so `cnt` saturates and no `valid` is produced.
- `busy = (state == MEASURE)`.

## Timing
- Reset (`rst = 0`, asynchronous): `q = 0`, `valid = 0`, `ovf = 0`, `busy = 0`, state IDLE, `cnt = 0`, `tick_q = 0`, `pend = 0`.
- Reset mid-measurement discards the count in progress. After release, the first edge only arms the block.
- A `tick_in` held high across reset release is not an edge. The IDLE→ARMED cycle lets `tick_q` load first.
- Capture latency, no sync: `q`, `ovf` and `valid` update on the clock edge that samples the `tick_in` rising edge, and are visible in the following cycle.
  - `valid` is high for exactly one cycle per capture.
  - `q` holds until the next capture or reset.
- `en` rising to the first possible capture: 1 cycle to ARMED, then the arming edge, then one full period.
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- `PERIOD_METER_SYNC_EN` defined: `tick_in` passes through a 2-flop synchronizer before edge detection.
  - This adds exactly 2 cycles of capture latency.
  - Measured periods are unchanged.
  - The synchronizer flops reset to 0.
- Undefined: `tick_in` feeds edge detection directly. The source must be `clk`-synchronous, as the timer's `tick` is.

## Test plan
- `en = 1`, one-cycle `tick_in` pulses every 5 cycles, 4 pulses → first pulse arms only; 3 `valid` pulses, each with `q = 5` and `ovf = 0`; `busy = 1` after the first pulse.
- Pulses with gaps 3, 7, 2 → successive captures `q = 3`, `7`, `2`, each with `valid` one cycle wide; no dead cycle between the 2-cycle period and the preceding capture.
- Two pulses 300 cycles apart, `WIDTH = 8` → `q = 255`, `ovf = 1`. A following 4-cycle period gives `q = 4`, `ovf = 0`.
- `en` dropped in the same cycle as a pulse edge → no `valid`, `q` unchanged, state IDLE, `busy = 0`. On re-enable, the next pulse arms only.
- `rst` asserted 3 cycles into a 10-cycle period, `tick_in` held high across release → all outputs 0 immediately; no edge detected at release; the next two pulses 6 apart give `q = 6`.
- With `PERIOD_METER_SYNC_EN`: repeat the 5-cycle test → same `q = 5` values, with `valid` 2 cycles later than without the macro.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Measures the number of clk cycles between consecutive rising edges of
//   tick_in and reports the most recent interval on q (saturating at
//   2^WIDTH-1, with ovf flagging saturation). The first edge after arming
//   only starts timing; every later edge captures a period, with no dead
//   cycle between back-to-back periods.
//
//   Optional feature macro: PERIOD_METER_SYNC_EN
//     defined   - tick_in passes through a 2-flop synchronizer before edge
//                 detection (adds 2 cycles of capture latency, periods
//                 unchanged).
//     undefined - tick_in must be clk-synchronous and feeds edge detection
//                 directly.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   measurement enable (level)
//   tick_in  in   pulse stream to measure
//   q        out  [WIDTH-1:0] last captured period in cycles (saturating)
//   valid    out  one-cycle pulse when q/ovf have just been updated
//   ovf      out  captured period saturated
//   busy     out  high while a period is being timed
module tick_period_meter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             tick_q;
  logic             tick_s;
  logic             edge_w;

`ifdef PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], tick_in};
    end
  end

  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_in;
`endif

  assign edge_w = tick_s & ~tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      tick_q  <= tick_s;
    end
  end

  // en low takes priority over a coincident edge, so disabling never captures.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (edge_w) begin
          state_d = S_MEASURE;
          cnt_d   = CNT_ONE;
          pend_d  = 1'b0;
        end
      end
      S_MEASURE: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (edge_w) begin
          q_d     = cnt_q;
          ovf_d   = pend_q;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
          pend_d  = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          // Counter parks at full scale; pend remembers the period ran long.
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == S_MEASURE);

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter
//   Self-checking bench for tick_period_meter (WIDTH = 8). A timestamp-based
//   reference model predicts q/valid/ovf/busy each cycle from the edge times
//   of tick_in; directed scenarios are followed by randomized pulse trains.
module tb_tick_period_meter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned QMAX  = (1 << WIDTH) - 1;
`ifdef PERIOD_METER_SYNC_EN
  localparam int unsigned DLY = 2;
`else
  localparam int unsigned DLY = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             tick_in;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             ovf;
  logic             busy;

  tick_period_meter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick_in(tick_in),
    .q      (q),
    .valid  (valid),
    .ovf    (ovf),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = disabled, 1 = waiting for first edge,
  // 2 = timing since last_edge. Periods are differences of edge timestamps.
  int unsigned m_mode;
  longint      m_cyc;
  longint      m_last;
  int unsigned m_q;
  bit          m_ovf;
  bit          m_valid;
  bit          m_prev;
  bit          m_hist[2];
  int unsigned vcount;

  function automatic void model_reset();
    m_mode  = 0;
    m_q     = 0;
    m_ovf   = 0;
    m_valid = 0;
    m_prev  = 0;
    m_hist[0] = 0;
    m_hist[1] = 0;
  endfunction

  function automatic void model_clock(input bit e, input bit t);
    bit     seen;
    bit     ev;
    longint p;
    seen = (DLY == 2) ? m_hist[1] : t;
    m_hist[1] = m_hist[0];
    m_hist[0] = t;
    ev = seen && !m_prev;
    m_prev = seen;
    m_valid = 0;
    if (!e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (ev) begin
      if (m_mode == 2) begin
        p = m_cyc - m_last;
        m_q     = (p > QMAX) ? QMAX : int'(p);
        m_ovf   = (p > QMAX);
        m_valid = 1;
      end
      m_mode = 2;
      m_last = m_cyc;
    end
  endfunction

  task automatic check_outputs();
    check("q", q, m_q);
    check("valid", valid, m_valid);
    check("ovf", ovf, m_ovf);
    check("busy", busy, (m_mode == 2));
  endtask

  task automatic step(input bit e, input bit t);
    @(negedge clk);
    en      = e;
    tick_in = t;
    @(posedge clk);
    m_cyc++;
    if (rst) model_clock(e, t);
    else     model_reset();
    #1;
    if (valid) vcount++;
    check_outputs();
  endtask

  task automatic pulse(input int unsigned gap, input int unsigned width = 1);
    for (int unsigned i = 0; i < gap; i++) step(1'b1, (i < width));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_q", q, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    tick_in = 1'b0;
    m_cyc   = 0;
    m_last  = 0;
    vcount  = 0;
    model_reset();
    #1;
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 5-cycle pulses, four of them: first arms, three captures.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    vcount = 0;
    repeat (4) pulse(5);
    check("t1_vcount", vcount, 3);
    check("t1_q", q, 5);
    check("t1_busy", busy, 1);

    // Gaps 3, 7, 2 back to back.
    pulse(3);
    pulse(7);
    pulse(2);

    // Long period saturates, next short one recovers.
    pulse(300);
    pulse(4);
    check("t3_q_sat", q, QMAX);
    check("t3_ovf", ovf, 1);
    pulse(4);
    check("t3_q4", q, 4);
    check("t3_ovf_clr", ovf, 0);

    // en dropped on the same cycle as an edge.
    pulse(6);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("t4_q_hold", q, 4);
    check("t4_busy", busy, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    pulse(5);
    pulse(5);
    pulse(5);

    // Reset 3 cycles into a 10-cycle period, tick_in high across release.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    tick_in = 1'b1;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t5_busy_no_edge", busy, 0);
    step(1'b1, 1'b0);
    pulse(6);
    pulse(6);
    pulse(6);
    check("t5_q6", q, 6);

    // Randomized pulse trains with occasional disables and long gaps.
    for (int i = 0; i < 120; i++) begin
      int unsigned gap;
      int unsigned w;
      if ($urandom_range(0, 9) == 0) begin
        for (int unsigned k = 0; k < $urandom_range(1, 4); k++)
          step(1'b0, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 19) == 0) gap = $urandom_range(250, 262);
      else                            gap = $urandom_range(2, 14);
      w = $urandom_range(1, gap - 1);
      pulse(gap, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
